// File: rtl/game_round_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : game_round_sequencer                                        |
// | Description : Round controller for a reaction game. Edge-detects the      |
// |               start button, waits READY_TICKS cycles, then counts hits    |
// |               and misses until the round is won or lost. Drives the       |
// |               countdown timer's start / miss / game_end pulses and        |
// |               consumes its game_over level.                               |
// | Revision    : 1.0  - initial release                                     |
// +--------------------------------------------------------------------------+
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   btn_start      in   start button level (already synchronised)
//   hit            in   1-cycle pulse, target hit
//   miss_in        in   1-cycle pulse, target missed
//   timer_over     in   timer block game_over level
//   timer_start    out  1-cycle pulse, first PLAY cycle
//   timer_miss     out  1-cycle pulse, one cycle after a counted miss
//   timer_game_end out  1-cycle pulse, first cycle in WIN or LOSE
//   state          out  IDLE=0 READY=1 PLAY=2 WIN=3 LOSE=4
//   score          out  hits counted this round
//   miss_count     out  misses counted this round
//   win / lose     out  round result levels, held until reset
//------------------------------------------------------------------------------
module game_round_sequencer #(
    parameter int READY_TICKS = 150000,
    parameter int TARGET_HITS = 10,
    parameter int MAX_MISSES  = 5,
    parameter int SCORE_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               hit,
    input  logic               miss_in,
    input  logic               timer_over,
    output logic               timer_start,
    output logic               timer_miss,
    output logic               timer_game_end,
    output logic [2:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         miss_count,
    output logic               win,
    output logic               lose
);

    localparam int                 c_RDY_W      = (READY_TICKS > 1) ? $clog2(READY_TICKS) : 1;
    localparam logic [c_RDY_W-1:0] c_READY_LOAD = c_RDY_W'(READY_TICKS - 1);
    localparam logic [SCORE_W-1:0] c_TARGET     = SCORE_W'(TARGET_HITS);
    localparam logic [3:0]         c_MAX_MISS   = 4'(MAX_MISSES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 btn_start_q;
    logic [c_RDY_W-1:0]   ready_cnt_q, ready_cnt_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           miss_count_q, miss_count_d;
    logic                 win_q, win_d;
    logic                 lose_q, lose_d;
    logic                 timer_start_q, timer_start_d;
    logic                 timer_miss_q, timer_miss_d;
    logic                 timer_game_end_q, timer_game_end_d;

    logic                 w_start_edge;
    logic [SCORE_W-1:0]   w_score_inc;
    logic [3:0]           w_miss_inc;
    logic                 w_miss_limit;
    logic                 w_hit_limit;

    assign w_start_edge = btn_start & ~btn_start_q;
    assign w_score_inc  = score_q + SCORE_W'(1);
    assign w_miss_inc   = miss_count_q + 4'd1;
    // Limits are evaluated on the post-increment value so the transition
    // happens in the same cycle the deciding event is counted.
    assign w_miss_limit = miss_in && (w_miss_inc == c_MAX_MISS);
    assign w_hit_limit  = hit && (w_score_inc == c_TARGET);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            btn_start_q      <= 1'b0;
            ready_cnt_q      <= '0;
            score_q          <= '0;
            miss_count_q     <= '0;
            win_q            <= 1'b0;
            lose_q           <= 1'b0;
            timer_start_q    <= 1'b0;
            timer_miss_q     <= 1'b0;
            timer_game_end_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            btn_start_q      <= btn_start;
            ready_cnt_q      <= ready_cnt_d;
            score_q          <= score_d;
            miss_count_q     <= miss_count_d;
            win_q            <= win_d;
            lose_q           <= lose_d;
            timer_start_q    <= timer_start_d;
            timer_miss_q     <= timer_miss_d;
            timer_game_end_q <= timer_game_end_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ready_cnt_d      = ready_cnt_q;
        score_d          = score_q;
        miss_count_d     = miss_count_q;
        win_d            = win_q;
        lose_d           = lose_q;
        timer_start_d    = 1'b0;
        timer_miss_d     = 1'b0;
        timer_game_end_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_start_edge) begin
                    state_d      = S_READY;
                    ready_cnt_d  = c_READY_LOAD;
                    score_d      = '0;
                    miss_count_d = '0;
                end
            end

            S_READY: begin
                if (ready_cnt_q == '0) begin
                    state_d       = S_PLAY;
                    timer_start_d = 1'b1;
                end else begin
                    ready_cnt_d = ready_cnt_q - c_RDY_W'(1);
                end
            end

            S_PLAY: begin
                if (timer_over) begin
                    // Timer expiry wins over any same-cycle hit or miss.
                    state_d          = S_LOSE;
                    lose_d           = 1'b1;
                    timer_game_end_d = 1'b1;
                end else begin
                    if (miss_in) begin
                        miss_count_d = w_miss_inc;
                        timer_miss_d = 1'b1;
                        if (w_miss_limit) begin
                            state_d          = S_LOSE;
                            lose_d           = 1'b1;
                            timer_game_end_d = 1'b1;
                        end
                    end
                    if (hit) begin
                        score_d = w_score_inc;
                        // A loss on the same cycle takes precedence.
                        if (w_hit_limit && !w_miss_limit) begin
                            state_d          = S_WIN;
                            win_d            = 1'b1;
                            timer_game_end_d = 1'b1;
                        end
                    end
                end
            end

            S_WIN, S_LOSE: begin
                // Terminal until reset: the timer block only reloads on reset.
            end

            default: begin
                state_d      = S_IDLE;
                ready_cnt_d  = '0;
                score_d      = '0;
                miss_count_d = '0;
                win_d        = 1'b0;
                lose_d       = 1'b0;
            end
        endcase
    end

    assign state          = state_q;
    assign score          = score_q;
    assign miss_count     = miss_count_q;
    assign win            = win_q;
    assign lose           = lose_q;
    assign timer_start    = timer_start_q;
    assign timer_miss     = timer_miss_q;
    assign timer_game_end = timer_game_end_q;

endmodule
`default_nettype wire
